// File: rtl/clb_cfg_pkg.sv
// Shared constants for the CLB configuration loader: sync word, loader states
// and the CLB frame field map used by the configuration register decode.
package clb_cfg_pkg;

  localparam logic [3:0] SYNC = 4'b0010;

  localparam int unsigned CFG_NCLB    = 16;
  localparam int unsigned CFG_ADDR_W  = 8;
  localparam int unsigned CFG_FRAME_W = 37;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_FRAME,
    S_PAR,
    S_DONE,
    S_ERR
  } state_e;

  // Field offsets (LSB) and widths within a frame; bit 36 is received first.
  localparam int unsigned FLD_LUT_LSB   = 21;
  localparam int unsigned FLD_LUT_W     = 16;
  localparam int unsigned FLD_COMB_LSB  = 19;
  localparam int unsigned FLD_COMB_W    = 2;
  localparam int unsigned FLD_MUX_LSB   = 9;
  localparam int unsigned FLD_MUX_W     = 10;
  localparam int unsigned FLD_O2M_LSB   = 3;
  localparam int unsigned FLD_O2M_W     = 6;
  localparam int unsigned FLD_DQMUX_LSB = 1;
  localparam int unsigned FLD_DQMUX_W   = 2;
  localparam int unsigned FLD_FLOP_LSB  = 0;
  localparam int unsigned FLD_FLOP_W    = 1;

  // Frame payload as seen by a CLB configuration register.
  typedef struct packed {
    logic [FLD_LUT_W-1:0]   lut;
    logic [FLD_COMB_W-1:0]  comboption;
    logic [FLD_MUX_W-1:0]   mux_sel;      // mux2 in the top pair, mux6 in the bottom pair
    logic [FLD_O2M_W-1:0]   o2m;          // o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1
    logic [FLD_DQMUX_W-1:0] dqmux;
    logic                   floporlatch;
  } cfg_frame_t;

  // Select of mux k (2..6) from a raw frame.
  function automatic logic [1:0] frame_mux_sel(input logic [CFG_FRAME_W-1:0] frame,
                                               input int unsigned k);
    int unsigned lsb;
    lsb = FLD_MUX_LSB + 2 * (6 - k);
    return frame[lsb +: 2];
  endfunction

endpackage

// File: rtl/clb_cfg_shreg.sv
// Serial-in/parallel-out shifter with running parity and a bit counter whose
// terminal-count flag marks the last bit of a W-bit field.
import clb_cfg_pkg::*;

module clb_cfg_shreg #(
  parameter int unsigned W = CFG_FRAME_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_din,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_next_c,
  output logic         o_par,
  output logic         o_tc_c
);

  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     r_q;
  logic             r_par;
  logic [CNT_W-1:0] r_cnt;

  assign o_q      = r_q;
  assign o_par    = r_par;
  assign o_next_c = {r_q[W-2:0], i_din};
  assign o_tc_c   = (r_cnt == CNT_W'(W - 1));

  // Counter wraps on the last bit so back-to-back fields need no extra clear.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_q   <= '0;
      r_par <= 1'b0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_q   <= o_next_c;
      r_par <= r_par ^ i_din;
      r_cnt <= o_tc_c ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial configuration loader: finds the sync word, reads the frame count and
// writes one parity-checked frame per CLB into the configuration registers.
import clb_cfg_pkg::*;

module clb_cfg_loader #(
  parameter int unsigned NCLB    = CFG_NCLB,
  parameter int unsigned ADDR_W  = CFG_ADDR_W,
  parameter int unsigned FRAME_W = CFG_FRAME_W
) (
  input  logic               i_k,
  input  logic               i_rst,
  input  logic               i_din,
  input  logic               i_dvalid,
  output logic [ADDR_W-1:0]  o_cfg_addr,
  output logic [FRAME_W-1:0] o_cfg_data,
  output logic               o_cfg_we,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  state_e r_state;
  state_e w_state_nxt;

  logic [3:0]         r_hist;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_cfg_addr;
  logic [FRAME_W-1:0] r_cfg_data;
  logic               r_we;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic [3:0] w_hist_nxt;
  logic       w_len_en;
  logic       w_frm_en;
  logic       w_frm_clr;
  logic       w_we_nxt;
  logic       w_addr_clr;
  logic       w_addr_inc;
  logic       w_done_set;
  logic       w_err_set;

  logic [ADDR_W-1:0]  w_len_q;
  logic [ADDR_W-1:0]  w_len_next;
  logic               w_len_tc;
  logic               w_unused_len_par;
  logic [FRAME_W-1:0] w_frm_q;
  logic [FRAME_W-1:0] w_unused_frm_next;
  logic               w_frm_par;
  logic               w_frm_tc;

  // Frame-count field; its register keeps N for the rest of the transfer.
  clb_cfg_shreg #(.W(ADDR_W)) u_len (
    .i_clk    (i_k),
    .i_rst    (i_rst),
    .i_clr    (1'b0),
    .i_en     (w_len_en),
    .i_din    (i_din),
    .o_q      (w_len_q),
    .o_next_c (w_len_next),
    .o_par    (w_unused_len_par),
    .o_tc_c   (w_len_tc)
  );

  clb_cfg_shreg #(.W(FRAME_W)) u_frame (
    .i_clk    (i_k),
    .i_rst    (i_rst),
    .i_clr    (w_frm_clr),
    .i_en     (w_frm_en),
    .i_din    (i_din),
    .o_q      (w_frm_q),
    .o_next_c (w_unused_frm_next),
    .o_par    (w_frm_par),
    .o_tc_c   (w_frm_tc)
  );

  always_ff @(posedge i_k) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Everything but a pending strobe freezes on edges without DVALID.
  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_len_en    = 1'b0;
    w_frm_en    = 1'b0;
    w_frm_clr   = 1'b0;
    w_we_nxt    = 1'b0;
    w_addr_clr  = 1'b0;
    w_addr_inc  = 1'b0;
    w_done_set  = 1'b0;
    w_err_set   = 1'b0;
    if (i_dvalid) begin
      unique case (r_state)
        S_IDLE: begin
          w_hist_nxt = {r_hist[2:0], i_din};
          if (w_hist_nxt == SYNC) begin
            w_state_nxt = S_LEN;
          end
        end
        S_LEN: begin
          w_len_en = 1'b1;
          if (w_len_tc) begin
            if (w_len_next == '0) begin
              w_state_nxt = S_DONE;
              w_done_set  = 1'b1;
            end else if (w_len_next > ADDR_W'(NCLB)) begin
              w_state_nxt = S_ERR;
              w_err_set   = 1'b1;
            end else begin
              w_state_nxt = S_FRAME;
              w_addr_clr  = 1'b1;
            end
          end
        end
        S_FRAME: begin
          w_frm_en = 1'b1;
          if (w_frm_tc) begin
            w_state_nxt = S_PAR;
          end
        end
        S_PAR: begin
          w_frm_clr = 1'b1;
          if (w_frm_par ^ i_din) begin
            w_state_nxt = S_ERR;
            w_err_set   = 1'b1;
          end else begin
            w_we_nxt   = 1'b1;
            w_addr_inc = 1'b1;
            if (r_addr == w_len_q - ADDR_W'(1)) begin
              w_state_nxt = S_DONE;
              w_done_set  = 1'b1;
            end else begin
              w_state_nxt = S_FRAME;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_k) begin
    if (i_rst) begin
      r_hist     <= '0;
      r_addr     <= '0;
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_hist <= w_hist_nxt;
      r_we   <= w_we_nxt;
      if (w_addr_clr) begin
        r_addr <= '0;
      end else if (w_addr_inc) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      if (w_we_nxt) begin
        r_cfg_addr <= r_addr;
        r_cfg_data <= w_frm_q;
      end
      r_busy <= (w_state_nxt == S_LEN) || (w_state_nxt == S_FRAME) ||
                (w_state_nxt == S_PAR);
      if (w_done_set) begin
        r_done <= 1'b1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_cfg_addr = r_cfg_addr;
  assign o_cfg_data = r_cfg_data;
  assign o_cfg_we   = r_we;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Scoreboard bench for clb_cfg_loader: a bit-level stream model predicts
// writes and DONE/BUSY/ERR edges; a negedge monitor checks the DUT against it.
module tb_clb_cfg_loader;

  localparam int unsigned NCLB    = 16;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned FRAME_W = 37;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               din = 1'b0;
  logic               dvalid = 1'b0;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [FRAME_W-1:0] cfg_data;
  logic               cfg_we;
  logic               busy;
  logic               done;
  logic               err;

  always #5 clk = ~clk;

  clb_cfg_loader #(.NCLB(NCLB), .ADDR_W(ADDR_W), .FRAME_W(FRAME_W)) dut (
    .i_k        (clk),
    .i_rst      (rst),
    .i_din      (din),
    .i_dvalid   (dvalid),
    .o_cfg_addr (cfg_addr),
    .o_cfg_data (cfg_data),
    .o_cfg_we   (cfg_we),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  typedef struct { bit d; bit v; } ent_t;
  typedef struct { int addr; logic [FRAME_W-1:0] data; int cyc; } wr_t;

  ent_t stim[$];
  wr_t  sb[$];
  int   wr_cyc[$];
  wr_t  mon_e;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int exp_busy_cyc = -1;
  int exp_done_cyc = -1;
  int exp_err_cyc = -1;
  bit seen_busy, seen_done, seen_err;
  logic prev_busy = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and checks status edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_we) begin
        wr_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_we: addr=%0d data=%h but no write expected (cycle %0d)",
                   cfg_addr, cfg_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("we_addr", 64'(cfg_addr), 64'(mon_e.addr));
          check("we_data", 64'(cfg_data), 64'(mon_e.data));
          check("we_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
      if (busy && !prev_busy) begin
        seen_busy = 1'b1;
        check("busy_rise_cycle", 64'(cyc), 64'(exp_busy_cyc));
      end
      if (done && !prev_done) begin
        seen_done = 1'b1;
        check("done_rise_cycle", 64'(cyc), 64'(exp_done_cyc));
      end
      if (err && !prev_err) begin
        seen_err = 1'b1;
        check("err_rise_cycle", 64'(cyc), 64'(exp_err_cyc));
        check("busy_low_at_err", 64'(busy), 64'(0));
      end
    end
    prev_busy = busy;
    prev_done = done;
    prev_err  = err;
  end

  // Reference model over the list of valid bits; entry k is sampled by the
  // edge that makes cyc == base + k + 1, where the monitor sees its effect.
  task automatic model(input int base);
    bit vb[$];
    int vidx[$];
    int h, i, n, ones;
    logic [FRAME_W-1:0] d;
    foreach (stim[k]) if (stim[k].v) begin
      vb.push_back(stim[k].d);
      vidx.push_back(k);
    end
    h = 0;
    i = 0;
    while (i < vb.size()) begin
      h = (h * 2 + int'(vb[i])) % 16;
      i++;
      if (h == 2) break;
    end
    if (h != 2) return;
    exp_busy_cyc = base + vidx[i-1] + 1;
    if (i + int'(ADDR_W) > vb.size()) return;
    n = 0;
    for (int k = 0; k < int'(ADDR_W); k++) begin
      n = n * 2 + int'(vb[i]);
      i++;
    end
    if (n == 0) begin
      exp_done_cyc = base + vidx[i-1] + 1;
      return;
    end
    if (n > int'(NCLB)) begin
      exp_err_cyc = base + vidx[i-1] + 1;
      return;
    end
    for (int f = 0; f < n; f++) begin
      if (i + int'(FRAME_W) + 1 > vb.size()) return;
      d = '0;
      ones = 0;
      for (int k = 0; k < int'(FRAME_W); k++) begin
        d = d * 2 + FRAME_W'(vb[i]);
        ones += int'(vb[i]);
        i++;
      end
      ones += int'(vb[i]);
      i++;
      if (ones % 2 != 0) begin
        exp_err_cyc = base + vidx[i-1] + 1;
        return;
      end
      sb.push_back('{addr: f, data: d, cyc: base + vidx[i-1] + 1});
      if (f == n - 1) exp_done_cyc = base + vidx[i-1] + 1;
    end
  endtask

  function automatic void push_bits(input logic [63:0] val, input int w);
    for (int k = w - 1; k >= 0; k--) stim.push_back('{d: val[k], v: 1'b1});
  endfunction

  function automatic void push_stall(input int n);
    for (int k = 0; k < n; k++) stim.push_back('{d: 1'($urandom), v: 1'b0});
  endfunction

  // Frame plus even-parity bit (optionally inverted), with stalls strictly inside.
  function automatic void push_frame(input logic [FRAME_W-1:0] d, input bit flip, input int nstall);
    int at[FRAME_W];
    foreach (at[k]) at[k] = 0;
    for (int s = 0; s < nstall; s++) at[$urandom_range(1, FRAME_W - 1)]++;
    for (int k = 0; k < int'(FRAME_W); k++) begin
      push_stall(at[k]);
      push_bits(64'(d[FRAME_W-1-k]), 1);
    end
    push_bits(64'((^d) ^ flip), 1);
  endfunction

  function automatic void push_header(input int n);
    push_bits(64'hF, 4);
    push_bits(64'h2, 4);
    push_bits(64'(n), int'(ADDR_W));
  endfunction

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst = 1'b1;
    dvalid = 1'($urandom);
    din = 1'($urandom);
    @(negedge clk);
    rst = 1'b0;
    dvalid = 1'b0;
    if (chk) begin
      check("rst_cfg_addr", 64'(cfg_addr), 64'(0));
      check("rst_cfg_data", 64'(cfg_data), 64'(0));
      check("rst_cfg_we", 64'(cfg_we), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
    end
    sb.delete();
    wr_cyc.delete();
    exp_busy_cyc = -1;
    exp_done_cyc = -1;
    exp_err_cyc = -1;
    seen_busy = 1'b0;
    seen_done = 1'b0;
    seen_err = 1'b0;
  endtask

  task automatic run(input int drain);
    int base;
    base = cyc;
    model(base);
    foreach (stim[k]) begin
      din = stim[k].d;
      dvalid = stim[k].v;
      @(negedge clk);
    end
    dvalid = 1'b0;
    din = 1'b0;
    repeat (drain) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'(0));
    check("busy_seen", 64'(seen_busy), 64'(exp_busy_cyc >= 0));
    check("done_seen", 64'(seen_done), 64'(exp_done_cyc >= 0));
    check("err_seen", 64'(seen_err), 64'(exp_err_cyc >= 0));
    check("final_done", 64'(done), 64'(exp_done_cyc >= 0));
    check("final_err", 64'(err), 64'(exp_err_cyc >= 0));
    check("final_busy", 64'(busy),
          64'(exp_busy_cyc >= 0 && exp_done_cyc < 0 && exp_err_cyc < 0));
    stim.delete();
  endtask

  localparam logic [FRAME_W-1:0] F0 = 37'h0_0001_0116;
  localparam logic [FRAME_W-1:0] F1 = 37'h1_FFFF_FFFF;

  initial begin
    int n;
    int cut;
    logic [FRAME_W-1:0] rd;

    do_reset(1'b1);

    // Two back-to-back frames, no gaps
    push_header(2);
    push_frame(F0, 1'b0, 0);
    push_frame(F1, 1'b0, 0);
    run(4);
    check("write_count", 64'(wr_cyc.size()), 64'(2));
    if (wr_cyc.size() == 2) check("write_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'(38));

    // Same stream with five stall cycles inside each frame
    do_reset(1'b0);
    push_header(2);
    push_frame(F0, 1'b0, 5);
    push_frame(F1, 1'b0, 5);
    run(4);

    // Bad parity on frame 1, then a valid-looking stream that must be ignored
    do_reset(1'b0);
    push_header(2);
    push_frame(F0, 1'b0, 0);
    push_frame(F1, 1'b1, 0);
    push_header(1);
    push_frame(F0, 1'b0, 0);
    run(4);
    check("err_write_count", 64'(wr_cyc.size()), 64'(1));

    // Frame count above NCLB
    do_reset(1'b0);
    push_header(17);
    push_frame(F0, 1'b0, 0);
    run(4);

    // Frame count of zero
    do_reset(1'b0);
    push_header(0);
    push_frame(F0, 1'b0, 0);
    run(4);

    // Reset in the middle of frame 1, then a fresh single-frame stream
    do_reset(1'b0);
    push_header(2);
    push_frame(F0, 1'b0, 0);
    push_frame(F1, 1'b0, 0);
    cut = 16 + 38 + 20;
    while (stim.size() > cut) void'(stim.pop_back());
    run(2);
    do_reset(1'b1);
    push_header(1);
    push_frame(F1, 1'b0, 2);
    run(4);

    // Randomised streams: junk prefix, random count, data, stalls, parity faults
    for (int t = 0; t < 8; t++) begin
      do_reset(1'b0);
      for (int k = 0; k < int'($urandom_range(0, 5)); k++) push_bits(64'($urandom_range(0, 1)), 1);
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(1, 4));
      push_header(n);
      for (int f = 0; f < ((n > 4) ? 1 : n); f++) begin
        rd = FRAME_W'({$urandom(), $urandom()});
        push_frame(rd, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 4)));
      end
      push_stall(int'($urandom_range(0, 3)));
      run(4);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
